// File: rtl/fsm_proc_param.sv
// Parametrised stream processing controller.
// A start request in IDLE launches a word sequence that is walked one
// accepted word (in_valid=1) at a time. Processed words appear on a
// registered, valid-qualified output one cycle after acceptance. A stall
// in WAIT longer than WAIT_MAX cycles forces ERROR, and done_cnt counts
// completed transactions.
module fsm_proc_param #(
    parameter int unsigned    DW       = 8,
    parameter int unsigned    WAIT_MAX = 16,
    parameter logic [DW-1:0]  ERR_CODE = DW'(8'hEE),
    parameter int unsigned    CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          done,
    output logic          error,
    output logic          busy,
    output logic [CW-1:0] done_cnt
);

    // wait_cnt only ever holds 0 .. WAIT_MAX-1
    localparam int unsigned WCW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_READ  = 4'd2,
        S_PROC1 = 4'd3,
        S_PROC2 = 4'd4,
        S_PROC3 = 4'd5,
        S_WAIT  = 4'd6,
        S_DONE  = 4'd7,
        S_ERROR = 4'd8
    } state_e;

    state_e         state_q,     state_d;
    logic [DW-1:0]  data_out_q,  data_out_d;
    logic           out_valid_q, out_valid_d;
    logic           done_q,      done_d;
    logic [WCW-1:0] wait_cnt_q,  wait_cnt_d;
    logic [CW-1:0]  done_cnt_q,  done_cnt_d;

    // Next-state, output word and counter computation
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        data_out_d  = data_out_q;   // data_out holds while out_valid is low
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_START;
            end
            S_START: begin
                if (in_valid) state_d = data_in[0] ? S_READ : S_ERROR;
            end
            S_READ: begin
                if (in_valid) begin
                    data_out_d  = data_in;
                    out_valid_d = 1'b1;
                    if (data_in[3:1] == 3'b101) begin
                        state_d = S_PROC1;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_PROC1: begin
                if (in_valid) begin
                    data_out_d  = data_in + DW'(1);
                    out_valid_d = 1'b1;
                    state_d     = S_PROC2;
                end
            end
            S_PROC2: begin
                if (in_valid) begin
                    data_out_d  = {data_in[DW-2:0], 1'b0};
                    out_valid_d = 1'b1;
                    if (data_in[DW-1]) begin
                        state_d = S_PROC3;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_PROC3: begin
                if (in_valid) begin
                    data_out_d  = ~data_in;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_WAIT: begin
                // An exit word on the last allowed cycle beats the timeout
                if (in_valid && data_in[4]) begin
                    state_d = S_READ;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_DONE: begin
                if (in_valid) begin
                    data_out_d  = data_in;
                    out_valid_d = 1'b1;
                    done_d      = 1'b1;
                    done_cnt_d  = done_cnt_q + CW'(1);
                    state_d     = S_IDLE;
                end
            end
            S_ERROR: begin
                if (in_valid) begin
                    data_out_d  = ERR_CODE;
                    out_valid_d = 1'b1;
                    if (data_in[2:0] == 3'b111) state_d = S_IDLE;
                end
            end
            default: begin
                // Unreachable encodings recover to IDLE silently
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wait_cnt_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            wait_cnt_q  <= wait_cnt_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign done_cnt  = done_cnt_q;
    assign error     = (state_q == S_ERROR);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsm_proc_param.sv
// Directed testbench for fsm_proc_param (DW=8, WAIT_MAX=4, ERR_CODE=0xEE).
module tb_fsm_proc_param;

    localparam int unsigned DW       = 8;
    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CW       = 8;
    localparam logic [7:0]  ERR      = 8'hEE;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          done;
    logic          error;
    logic          busy;
    logic [CW-1:0] done_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fsm_proc_param #(
        .DW       (DW),
        .WAIT_MAX (WAIT_MAX),
        .CW       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .done      (done),
        .error     (error),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge
    task automatic step(input logic st, input logic iv, input logic [DW-1:0] d);
        start    = st;
        in_valid = iv;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    // Start + START word 0x01 -> READ
    task automatic to_read();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
    endtask

    // Happy path with optional stall cycles while in PROC2
    task automatic run_happy(input string name, input int stall, input logic [CW-1:0] exp_cnt);
        logic [7:0] exp_w [5];
        exp_w = '{8'h8A, 8'h8B, 8'h14, 8'h75, 8'h8A};
        step(1'b1, 1'b0, 8'h00);
        check({name, " busy after start"}, busy, 1);
        step(1'b0, 1'b1, 8'h01);
        check({name, " START no output"}, out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            // start is asserted mid-transaction and must be ignored
            step(1'b1, 1'b1, 8'h8A);
            check($sformatf("%s word%0d valid", name, i), out_valid, 1);
            check($sformatf("%s word%0d data", name, i), data_out, exp_w[i]);
            check($sformatf("%s word%0d done", name, i), done, (i == 4) ? 1 : 0);
            if (i == 1) begin
                for (int s = 0; s < stall; s++) begin
                    step(1'b0, 1'b0, 8'h8A);
                    check($sformatf("%s stall%0d valid", name, s), out_valid, 0);
                    check($sformatf("%s stall%0d busy", name, s), busy, 1);
                    check($sformatf("%s stall%0d hold", name, s), data_out, 8'h8B);
                end
            end
        end
        check({name, " idle after done"}, busy, 0);
        check({name, " done_cnt"}, done_cnt, exp_cnt);
        step(1'b0, 1'b0, 8'h00);
        check({name, " done pulse ends"}, done, 0);
        check({name, " data holds"}, data_out, 8'h8A);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        check("rst data_out", data_out, 0);
        check("rst out_valid", out_valid, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst error", error, 0);
        check("rst done_cnt", done_cnt, 0);
        rst = 1'b0;

        // IDLE ignores in_valid without start
        step(1'b0, 1'b1, 8'h01);
        check("idle no start", busy, 0);

        // 1. Happy path, 2. stalled happy path
        run_happy("happy", 0, 8'd1);
        run_happy("stall", 3, 8'd2);

        // 3. WAIT timeout into ERROR, then ERROR exit
        to_read();
        step(1'b0, 1'b1, 8'h00);
        check("t3 read valid", out_valid, 1);
        check("t3 read data", data_out, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h0F);
        check("t3 wait3 no error", error, 0);
        check("t3 wait3 no output", out_valid, 0);
        step(1'b0, 1'b0, 8'h00);
        check("t3 timeout error", error, 1);
        check("t3 timeout no output", out_valid, 0);
        step(1'b0, 1'b0, 8'h07);
        check("t3 error stall", error, 1);
        check("t3 error stall valid", out_valid, 0);
        step(1'b0, 1'b1, 8'h05);
        check("t3 err word1", data_out, ERR);
        check("t3 err word1 valid", out_valid, 1);
        check("t3 err stays", error, 1);
        step(1'b0, 1'b1, 8'h07);
        check("t3 err word2", data_out, ERR);
        check("t3 err exit", busy, 0);
        check("t3 err flag clear", error, 0);

        // 4. WAIT recovery after 2 cycles, 5b. wraparound in PROC1/PROC2
        to_read();
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        check("t4 recover no error", error, 0);
        check("t4 recover no output", out_valid, 0);
        step(1'b0, 1'b1, 8'h0A);
        check("t4 read data", data_out, 8'h0A);
        step(1'b0, 1'b1, 8'hFF);
        check("t5 inc wrap", data_out, 8'h00);
        check("t5 inc wrap valid", out_valid, 1);
        step(1'b0, 1'b1, 8'h7F);
        check("t5 shift", data_out, 8'hFE);
        // now in WAIT: exit word on the final allowed cycle beats timeout
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        check("t4 last-cycle exit", error, 0);
        check("t4 last-cycle busy", busy, 1);
        // READ 0x01 re-enters WAIT; counter must restart from zero
        step(1'b0, 1'b1, 8'h01);
        check("t4 reread data", data_out, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("t4 rewait no error", error, 0);
        step(1'b0, 1'b0, 8'h00);
        check("t4 rewait timeout", error, 1);
        step(1'b0, 1'b1, 8'h07);
        check("t4 exit err code", data_out, ERR);
        check("t4 exit idle", busy, 0);

        // 5a. START word with bit0 clear -> ERROR with no output
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        check("t5 start error", error, 1);
        check("t5 start no output", out_valid, 0);
        step(1'b0, 1'b1, 8'h07);
        check("t5 err exit data", data_out, ERR);
        check("t5 err exit idle", busy, 0);

        // 6. Reset while in PROC2
        to_read();
        step(1'b0, 1'b1, 8'h8A);
        step(1'b0, 1'b1, 8'h8A);
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h8A);
        rst = 1'b0;
        check("t6 data_out", data_out, 0);
        check("t6 out_valid", out_valid, 0);
        check("t6 done", done, 0);
        check("t6 busy", busy, 0);
        check("t6 error", error, 0);
        check("t6 done_cnt", done_cnt, 0);
        run_happy("post_rst", 0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
